// File: rtl/plus_adder32.sv
// Registered two's-complement adder built as a carry-select chain of BLK-bit ripple blocks.
// Produces sum, carry-out and signed overflow one clock after the operands are sampled.
module plus_adder32 #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NBLK = WIDTH / BLK;

  // BLK-bit ripple-carry add; bit BLK of the result is the block carry-out.
  function automatic logic [BLK:0] ripple_add(
    input logic [BLK-1:0] x,
    input logic [BLK-1:0] y,
    input logic           c_in
  );
    logic [BLK:0] res;
    logic         c;
    c   = c_in;
    res = '0;
    for (int i = 0; i < BLK; i++) begin
      res[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    res[BLK] = c;
    return res;
  endfunction

  logic [NBLK:0]    carry_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;

  assign carry_s[0] = cin;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK-1:0] x_s;
    logic [BLK-1:0] y_s;

    assign x_s = a[g*BLK +: BLK];
    assign y_s = b[g*BLK +: BLK];

    if (g == 0) begin : g_first
      logic [BLK:0] res_s;

      assign res_s             = ripple_add(x_s, y_s, carry_s[0]);
      assign sum_s[0 +: BLK]   = res_s[BLK-1:0];
      assign carry_s[1]        = res_s[BLK];
    end else begin : g_select
      // Both carry hypotheses are formed up front; the incoming carry only picks one.
      logic [BLK:0] res0_s;
      logic [BLK:0] res1_s;

      assign res0_s              = ripple_add(x_s, y_s, 1'b0);
      assign res1_s              = ripple_add(x_s, y_s, 1'b1);
      assign sum_s[g*BLK +: BLK] = carry_s[g] ? res1_s[BLK-1:0] : res0_s[BLK-1:0];
      assign carry_s[g+1]        = carry_s[g] ? res1_s[BLK]     : res0_s[BLK];
    end
  end

  // cin is not an operand sign, so overflow looks only at the operand and result MSBs.
  assign ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);

  // Output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sum      <= sum_s;
      cout     <= carry_s[NBLK];
      overflow <= ovf_s;
    end
  end

endmodule

// File: tb/tb_plus_adder32.sv
// Self-checking bench for plus_adder32: directed corner cases plus random vectors
// compared against an arithmetic reference model.
module tb_plus_adder32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;

  int n_cmp;
  int n_err;

  plus_adder32 #(.WIDTH(32), .BLK(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact unsigned sum for {cout,sum}, exact signed sum range test for overflow.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [63:0] u;
    longint      s;
    logic        ov;
    u  = {32'd0, x} + {32'd0, y} + {63'd0, c};
    s  = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {u[32], ov, u[31:0]};
  endfunction

  task automatic check(input string tag, input logic [33:0] exp_v);
    logic [33:0] obs;
    obs = {cout, overflow, sum};
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed cout/ovf/sum=%b/%b/%h expected %b/%b/%h",
             tag, obs[33], obs[32], obs[31:0], exp_v[33], exp_v[32], exp_v[31:0]);
    end
  endtask

  // Drive one vector, let one edge pass, then compare with the model.
  task automatic apply(input string tag, input logic [31:0] x, input logic [31:0] y, input logic c);
    a   = x;
    b   = y;
    cin = c;
    @(posedge clk);
    #1;
    check(tag, model(x, y, c));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    a   = 32'h1234_5678;
    b   = 32'h0FED_CBA9;
    cin = 1'b1;
    @(posedge clk);
    #1;
    check("reset", 34'd0);
    rst = 1'b0;

    // First post-reset result reflects the inputs present at the first rst=0 edge.
    apply("post_reset", 32'h1234_5678, 32'h0FED_CBA9, 1'b1);

    apply("max_plus_one",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    check("max_plus_one_k", {1'b0, 1'b1, 32'h8000_0000});
    apply("min_plus_m1",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("min_plus_m1_k",  {1'b1, 1'b1, 32'h7FFF_FFFF});
    apply("m4_plus_5",      32'hFFFF_FFFC, 32'h0000_0005, 1'b0);
    check("m4_plus_5_k",    {1'b1, 1'b0, 32'h0000_0001});
    apply("m999_plus_999",  32'hFFFF_FC19, 32'h0000_03E7, 1'b0);
    check("m999_k",         {1'b1, 1'b0, 32'h0000_0000});
    apply("ten_ten",        32'd10, 32'd10, 1'b0);
    check("ten_ten_k",      {1'b0, 1'b0, 32'h0000_0014});
    apply("m10_m20",        32'hFFFF_FFF6, 32'hFFFF_FFEC, 1'b0);
    check("m10_m20_k",      {1'b1, 1'b0, 32'hFFFF_FFE2});
    apply("165_1000",       32'd165, 32'd1000, 1'b0);
    check("165_1000_k",     {1'b0, 1'b0, 32'h0000_048D});
    apply("m500_2000",      32'hFFFF_FE0C, 32'd2000, 1'b0);
    check("m500_2000_k",    {1'b1, 1'b0, 32'h0000_05DC});
    apply("zero_cin",       32'd0, 32'd0, 1'b1);
    check("zero_cin_k",     {1'b0, 1'b0, 32'h0000_0001});
    apply("all1_plus_1",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("all1_plus_1_k",  {1'b1, 1'b0, 32'h0000_0000});
    apply("all1_cin",       32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    apply("max_cin",        32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    apply("full_chain",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    apply("alt_bits",       32'hAAAA_AAAA, 32'h5555_5555, 1'b1);

    // Mid-stream reset with nonzero inputs clears everything at that edge.
    a   = 32'h7FFF_FFFF;
    b   = 32'h7FFF_FFFF;
    cin = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset", 34'd0);
    rst = 1'b0;
    apply("after_mid_reset", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);

    // Back-to-back random vectors, some steered toward sign-boundary operands.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      if (i % 4 == 1) ra[30:0] = {31{ra[31]}} ^ 31'h7FFF_FFFF;
      if (i % 4 == 2) rb = ~ra;
      apply("random", ra, rb, rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
